// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
// and load-use-only stalling; without it, every RAW hazard on E or M stalls.
package hazard_pkg;

  // Forwarding mux selects for the Execute-stage ALU operands
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // ResultSrc encoding that marks a load
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Widest register address a tracking record can hold; narrower addresses
  // are zero-extended, which preserves equality comparisons.
  localparam int TRACK_ADDR_W = 8;

  typedef logic [TRACK_ADDR_W-1:0] trackAddr_t;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    trackAddr_t rd;
    trackAddr_t rs1;
    trackAddr_t rs2;
    logic       regWrite;
    logic       load;
  } trackRec_t;

  // A bubble writes nothing and reads x0, so it can never match anything
  localparam trackRec_t BUBBLE = '0;

  // True when this record produces a value that src consumes (x0 excluded)
  function automatic logic writesReg(input trackRec_t rec, input trackAddr_t src);
    return rec.regWrite && (rec.rd != '0) && (rec.rd == src);
  endfunction

endpackage

// File: rtl/hazard_track_reg.sv
// Pipeline tracking-record register: async active-low reset, synchronous
// clear (used to inject a bubble), otherwise loads its predecessor.
module hazard_track_reg
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  trackRec_t d,
  output trackRec_t q
);

  // Record register: bubble on reset or clear, else follow the previous stage
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking (<=) so every stage samples its predecessor's old value on the same edge.
    if (!reset) begin
      q <= BUBBLE;
    end else if (clear) begin
      q <= BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: stall/flush control, operand forwarding
// and a saturating stall-cycle counter.
// Build option: HAZARD_FORWARDING_EN (defined = forward from M/W and stall
// only on load-use; undefined = no forwarding, stall on any E/M producer).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCycles
);

  if (REG_ADDR_W > TRACK_ADDR_W) begin : gAddrWidthCheck
    $error("hazard_unit: REG_ADDR_W exceeds hazard_pkg::TRACK_ADDR_W");
  end

  trackRec_t  recD;
  trackRec_t  recE;
  trackRec_t  recM;
  trackRec_t  recW;
  trackAddr_t rs1DExt;
  trackAddr_t rs2DExt;
  logic       hazard;

  assign rs1DExt = trackAddr_t'(Rs1D);
  assign rs2DExt = trackAddr_t'(Rs2D);

  // Pack the Decode-stage instruction into a tracking record
  always_comb begin
    recD          = BUBBLE;
    recD.rd       = trackAddr_t'(RdD);
    recD.rs1      = rs1DExt;
    recD.rs2      = rs2DExt;
    recD.regWrite = RegWriteD;
    recD.load     = (ResultSrcD == RESULT_SRC_LOAD);
  end

  // E takes a bubble whenever Execute is flushed; M and W always shift
  hazard_track_reg uRegE (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .d     (recD),
    .q     (recE)
  );

  hazard_track_reg uRegM (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     (recE),
    .q     (recM)
  );

  hazard_track_reg uRegW (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     (recM),
    .q     (recW)
  );

`ifdef HAZARD_FORWARDING_EN

  // Youngest producer wins: Memory stage before Writeback
  function automatic logic [1:0] fwdSelect(input trackRec_t m, input trackRec_t w,
                                           input trackAddr_t src);
    if (writesReg(m, src)) return FWD_M;
    if (writesReg(w, src)) return FWD_W;
    return FWD_NONE;
  endfunction

  // Only a load in E cannot be forwarded in time to its consumer in D
  assign hazard = recE.load && (writesReg(recE, rs1DExt) || writesReg(recE, rs2DExt));

  assign ForwardAE = fwdSelect(recM, recW, recE.rs1);
  assign ForwardBE = fwdSelect(recM, recW, recE.rs2);

  // Fields the forwarding build never inspects
  logic unusedFields;
  assign unusedFields = ^{recM.rs1, recM.rs2, recM.load, recW.rs1, recW.rs2, recW.load};

`else

  // No bypass paths: wait until the producer leaves M (register file writes
  // on the falling edge, so W is already visible to Decode)
  assign hazard = writesReg(recE, rs1DExt) || writesReg(recE, rs2DExt) ||
                  writesReg(recM, rs1DExt) || writesReg(recM, rs2DExt);

  assign ForwardAE = FWD_NONE;
  assign ForwardBE = FWD_NONE;

  // Fields the non-forwarding build never inspects
  logic unusedFields;
  assign unusedFields = ^{recE.rs1, recE.rs2, recE.load,
                          recM.rs1, recM.rs2, recM.load, recW};

`endif

  // Stall/flush control; a taken branch squashes the stalled instruction anyway
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Count Decode stall cycles, holding at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCycles <= '0;
    end else if (StallD && (StallCycles != '1)) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver applies directed and random
// Decode-stage instructions, an instruction-level pipeline model predicts
// the outputs, and a monitor compares them on the falling clock edge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic       RegWriteD = 1'b0;
  logic [1:0] ResultSrcD = '0;
  logic       PCSrcE = 1'b0;

  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCycles;

  logic        satStallF, satStallD, satFlushD, satFlushE;
  logic [1:0]  satForwardAE, satForwardBE;
  logic [1:0]  satStallCycles;

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCycles(StallCycles)
  );

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(satStallF), .StallD(satStallD), .FlushD(satFlushD), .FlushE(satFlushE),
    .ForwardAE(satForwardAE), .ForwardBE(satForwardBE), .StallCycles(satStallCycles)
  );

  always #5 clk = ~clk;

  // One cycle of Decode-stage stimulus; rst is the level of the active-low reset
  typedef struct {
    logic [4:0] rd, rs1, rs2;
    bit         rw;
    logic [1:0] src;
    bit         pc;
    bit         rst;
  } stim_t;

  // An instruction travelling down E/M/W
  typedef struct {
    logic [4:0] rd, rs1, rs2;
    bit         writes;
    bit         isLoad;
  } instr_t;

  typedef struct {
    bit         stallF, stallD, flushD, flushE;
    logic [1:0] fwdA, fwdB;
    int         cnt16, cnt2;
  } exp_t;

  instr_t pipe[3];          // [0]=Execute, [1]=Memory, [2]=Writeback
  int     cnt16, cnt2;
  stim_t  prevS;
  exp_t   prevE;
  exp_t   expQ[$];
  int     nVec = 0;
  int     nMis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic bit produces(input instr_t p, input logic [4:0] r);
    return p.writes && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  // Forward from the youngest later stage holding the value: M=2'b10, W=2'b01
  function automatic logic [1:0] fwdCode(input logic [4:0] r);
    if (produces(pipe[1], r)) return 2'b10;
    if (produces(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit   haz;
    e   = '{default: 0};
    haz = 1'b0;
    if (!s.rst) return e;
`ifdef HAZARD_FORWARDING_EN
    haz    = pipe[0].isLoad && (produces(pipe[0], s.rs1) || produces(pipe[0], s.rs2));
    e.fwdA = fwdCode(pipe[0].rs1);
    e.fwdB = fwdCode(pipe[0].rs2);
`else
    for (int k = 0; k < 2; k++)
      if (produces(pipe[k], s.rs1) || produces(pipe[k], s.rs2)) haz = 1'b1;
`endif
    e.flushD = s.pc;
    e.flushE = s.pc || haz;
    e.stallF = haz && !s.pc;
    e.stallD = haz && !s.pc;
    e.cnt16  = cnt16;
    e.cnt2   = cnt2;
    return e;
  endfunction

  // Advance the model over one rising edge, then apply and predict the next cycle
  task automatic step(input stim_t s);
    exp_t   e;
    instr_t d;
    @(posedge clk);
    if (!prevS.rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = bubble();
      cnt16 = 0;
      cnt2  = 0;
    end else begin
      if (prevE.stallD) begin
        cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
        cnt2  = (cnt2 < 3) ? cnt2 + 1 : 3;
      end
      d = '{rd: prevS.rd, rs1: prevS.rs1, rs2: prevS.rs2, writes: prevS.rw,
            isLoad: (prevS.src == 2'b01)};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = prevE.flushE ? bubble() : d;
    end
    #1;
    Rs1D = s.rs1; Rs2D = s.rs2; RdD = s.rd; RegWriteD = s.rw;
    ResultSrcD = s.src; PCSrcE = s.pc; reset = s.rst;
    if (!s.rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = bubble();
      cnt16 = 0;
      cnt2  = 0;
    end
    e = predict(s);
    expQ.push_back(e);
    prevS = s;
    prevE = e;
  endtask

  function automatic stim_t ins(input int rd, input int rs1, input int rs2,
                                input bit rw, input bit ld);
    stim_t s;
    s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rw = rw;
    s.src = ld ? 2'b01 : 2'b00; s.pc = 1'b0; s.rst = 1'b1;
    return s;
  endfunction

  // Present an instruction and hold it in Decode for as long as it stalls
  task automatic issue(input stim_t s);
    int guard;
    guard = 0;
    step(s);
    while (prevE.stallD && guard < 4) begin
      step(s);
      guard++;
    end
  endtask

  task automatic doReset();
    stim_t s;
    s = ins(5, 5, 5, 1, 1);
    s.pc  = 1'b1;
    s.rst = 1'b0;
    step(s);
  endtask

  task automatic nops(input int n);
    repeat (n) step(ins(0, 0, 0, 0, 0));
  endtask

  // Monitor: compare whatever the driver predicted for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("StallF", 32'(StallF), 32'(e.stallF));
        check("StallD", 32'(StallD), 32'(e.stallD));
        check("FlushD", 32'(FlushD), 32'(e.flushD));
        check("FlushE", 32'(FlushE), 32'(e.flushE));
        check("ForwardAE", 32'(ForwardAE), 32'(e.fwdA));
        check("ForwardBE", 32'(ForwardBE), 32'(e.fwdB));
        check("StallCycles", 32'(StallCycles), 32'(e.cnt16));
        check("satStallD", 32'(satStallD), 32'(e.stallD));
        check("satStallCycles", 32'(satStallCycles), 32'(e.cnt2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
    cnt16 = 0;
    cnt2  = 0;
    prevS = ins(0, 0, 0, 0, 0);
    prevS.rst = 1'b0;
    prevE = '{default: 0};

    // Reset held with hazard-looking inputs and a taken branch: all outputs 0
    doReset();
    doReset();

    // ALU result forwarded from M, then from W
    issue(ins(5, 1, 2, 1, 0));
    issue(ins(6, 5, 3, 1, 0));
    issue(ins(7, 5, 0, 1, 0));
    nops(3);

    // Load-use: one bubble, then both operands from W, counter reads 1
    doReset();
    issue(ins(5, 1, 0, 1, 1));
    issue(ins(6, 5, 5, 1, 0));
    nops(3);

    // Load-use coinciding with a taken branch: flush wins, no stall counted
    step(ins(5, 1, 0, 1, 1));
    s = ins(6, 5, 0, 1, 0);
    s.pc = 1'b1;
    step(s);
    nops(3);

    // Writes to x0 never stall or forward
    issue(ins(0, 1, 2, 1, 0));
    issue(ins(0, 0, 0, 1, 1));
    issue(ins(3, 0, 0, 1, 0));
    nops(3);

    // Repeated RAW and load-use pairs drive the 2-bit counter into saturation
    doReset();
    repeat (5) begin
      issue(ins(5, 1, 2, 1, 0));
      issue(ins(6, 5, 0, 1, 0));
    end
    repeat (5) begin
      issue(ins(9, 1, 0, 1, 1));
      issue(ins(6, 0, 9, 1, 0));
    end
    nops(3);

    // Reset during the load-use stall cycle aborts the stall
    doReset();
    issue(ins(5, 1, 0, 1, 1));
    s = ins(6, 5, 0, 1, 0);
    s.rst = 1'b0;
    step(s);
    s.rst = 1'b1;
    step(s);
    nops(3);

    // Random traffic over a small register range to provoke frequent hazards
    repeat (1500) begin
      s.rd  = 5'($urandom_range(0, 3));
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rw  = 1'($urandom_range(0, 1));
      s.src = 2'($urandom_range(0, 3));
      s.pc  = ($urandom_range(0, 7) == 0);
      s.rst = ($urandom_range(0, 99) != 0);
      step(s);
    end
    nops(2);

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
